// File: rtl/zero_par_serializer.sv
// Parallel-to-serial stage feeding the zero-parity checker; the line idles high between frames.
// Optional parity append is enabled by defining ZERO_PARITY_APPEND_EN.
module zero_par_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             bit_valid_o,
    output logic             last_o,
    output logic             busy_o
);

`ifdef ZERO_PARITY_APPEND_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-1:0] load_word;
    logic [FRAME_LEN-1:0] next_word;
    logic                 at_last;
    logic                 take;

    function automatic logic head_bit(input logic [FRAME_LEN-1:0] w);
        return MSB_FIRST ? w[FRAME_LEN-1] : w[0];
    endfunction

    function automatic logic [FRAME_LEN-1:0] shift_word(input logic [FRAME_LEN-1:0] w);
        return MSB_FIRST ? {w[FRAME_LEN-2:0], 1'b0} : {1'b0, w[FRAME_LEN-1:1]};
    endfunction

`ifdef ZERO_PARITY_APPEND_EN
    // 1 when the word holds an even number of zeros, so each frame's zero count is even.
    function automatic logic zero_parity(input logic [WIDTH-1:0] d);
        return ~(^(~d));
    endfunction
`endif

    // Parity sits in the slot shifted out after the last data bit.
    always_comb begin
        load_word = '0;
`ifdef ZERO_PARITY_APPEND_EN
        if (MSB_FIRST)
            load_word = {data_i, zero_parity(data_i)};
        else
            load_word = {zero_parity(data_i), data_i};
`else
        load_word = data_i;
`endif
    end

    assign next_word = shift_word(shreg);
    assign at_last   = (state == SHIFT) && (bit_cnt == LAST_CNT);
    assign ready_o   = (state == IDLE) || at_last;
    assign take      = valid_i && ready_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            data_o      <= 1'b1;
            bit_valid_o <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= SHIFT;
                        shreg       <= load_word;
                        bit_cnt     <= '0;
                        data_o      <= head_bit(load_word);
                        bit_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        last_o      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        shreg   <= next_word;
                        bit_cnt <= bit_cnt + 1'b1;
                        data_o  <= head_bit(next_word);
                        last_o  <= (bit_cnt == LAST_CNT - 1'b1);
                    end else if (take) begin
                        // Reload on the final bit keeps back-to-back frames gapless.
                        shreg   <= load_word;
                        bit_cnt <= '0;
                        data_o  <= head_bit(load_word);
                        last_o  <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        data_o      <= 1'b1;
                        bit_valid_o <= 1'b0;
                        last_o      <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zero_par_serializer.sv
// Scoreboard bench for zero_par_serializer: MSB-first and LSB-first instances share one clock.
module tb_zero_par_serializer;

    localparam int W = 8;
`ifdef ZERO_PARITY_APPEND_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic d;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         reset;
    logic [W-1:0] data_m = '0, data_l = '0;
    logic         valid_m = 1'b0, valid_l = 1'b0;
    logic         ready_m, dout_m, bv_m, last_m, busy_m;
    logic         ready_l, dout_l, bv_l, last_l, busy_l;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 if (clk_en) clk = ~clk;

    zero_par_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .data_i(data_m), .valid_i(valid_m), .ready_o(ready_m),
        .data_o(dout_m), .bit_valid_o(bv_m), .last_o(last_m), .busy_o(busy_m)
    );

    zero_par_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .data_i(data_l), .valid_i(valid_l), .ready_o(ready_l),
        .data_o(dout_l), .bit_valid_o(bv_l), .last_o(last_l), .busy_o(busy_l)
    );

    // Reference frame: data bits in shift order, then the zero-count parity bit when enabled.
    task automatic push_word(input logic [W-1:0] w, input bit msb);
        int zeros;
        zeros = 0;
        for (int b = 0; b < W; b++) if (!w[b]) zeros++;
        for (int i = 0; i < W; i++)
            exp_q.push_back('{d: (msb ? w[W-1-i] : w[i]), last: (FL == W && i == W-1)});
        if (FL > W) exp_q.push_back('{d: ((zeros % 2) == 0), last: 1'b1});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({ready_m, dout_m, bv_m, last_m, busy_m} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_no_clk_msb: got %b want 11000", {ready_m, dout_m, bv_m, last_m, busy_m});
        end
        checks++;
        if ({ready_l, dout_l, bv_l, last_l, busy_l} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_no_clk_lsb: got %b want 11000", {ready_l, dout_l, bv_l, last_l, busy_l});
        end
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_msb(input logic [W-1:0] w, input string name);
        exp_t e;
        @(negedge clk);
        data_m = w;
        valid_m = 1'b1;
        checks++;
        if (ready_m !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_idle: got %b want 1", name, ready_m);
        end
        push_word(w, 1'b1);
        @(negedge clk);
        valid_m = 1'b0;
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s_queue_empty at bit %0d", name, i);
                break;
            end
            e = exp_q.pop_front();
            if ({dout_m, last_m, bv_m, busy_m, ready_m} !== {e.d, e.last, 1'b1, 1'b1, (i == FL-1)}) begin
                errors++;
                $display("FAIL %s_bit%0d: got d/last/bv/busy/rdy=%b want %b", name, i,
                         {dout_m, last_m, bv_m, busy_m, ready_m}, {e.d, e.last, 1'b1, 1'b1, (i == FL-1)});
            end
            @(negedge clk);
        end
        checks++;
        if ({dout_m, bv_m, last_m, busy_m, ready_m} !== 5'b10001) begin
            errors++;
            $display("FAIL %s_idle_after: got %b want 10001", name, {dout_m, bv_m, last_m, busy_m, ready_m});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        data_m = 8'hA5;
        valid_m = 1'b1;
        push_word(8'hA5, 1'b1);
        push_word(8'h0F, 1'b1);
        @(negedge clk);
        data_m = 8'h0F;
        for (int i = 0; i < 2*FL; i++) begin
            if (i == FL) valid_m = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_queue_empty at bit %0d", i);
                break;
            end
            e = exp_q.pop_front();
            if ({dout_m, last_m, bv_m, ready_m} !== {e.d, e.last, 1'b1, ((i % FL) == FL-1)}) begin
                errors++;
                $display("FAIL b2b_bit%0d: got d/last/bv/rdy=%b want %b", i,
                         {dout_m, last_m, bv_m, ready_m}, {e.d, e.last, 1'b1, ((i % FL) == FL-1)});
            end
            @(negedge clk);
        end
        checks++;
        if ({dout_m, bv_m, busy_m} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_idle_after: got %b want 100", {dout_m, bv_m, busy_m});
        end
    endtask

    task automatic test_lsb_first();
        exp_t e;
        @(negedge clk);
        data_l = 8'h01;
        valid_l = 1'b1;
        push_word(8'h01, 1'b0);
        @(negedge clk);
        valid_l = 1'b0;
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lsb_queue_empty at bit %0d", i);
                break;
            end
            e = exp_q.pop_front();
            if ({dout_l, last_l, bv_l, busy_l, ready_l} !== {e.d, e.last, 1'b1, 1'b1, (i == FL-1)}) begin
                errors++;
                $display("FAIL lsb_bit%0d: got %b want %b", i,
                         {dout_l, last_l, bv_l, busy_l, ready_l}, {e.d, e.last, 1'b1, 1'b1, (i == FL-1)});
            end
            @(negedge clk);
        end
        checks++;
        if ({dout_l, bv_l, last_l, busy_l, ready_l} !== 5'b10001) begin
            errors++;
            $display("FAIL lsb_idle_after: got %b want 10001", {dout_l, bv_l, last_l, busy_l, ready_l});
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        @(negedge clk);
        data_m = 8'h00;
        valid_m = 1'b1;
        push_word(8'h00, 1'b1);
        @(negedge clk);
        valid_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            e = exp_q.pop_front();
            if ({dout_m, bv_m} !== {e.d, 1'b1}) begin
                errors++;
                $display("FAIL midrst_pre_bit%0d: got %b want %b", i, {dout_m, bv_m}, {e.d, 1'b1});
            end
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dout_m, bv_m, last_m, busy_m, ready_m} !== 5'b10001) begin
            errors++;
            $display("FAIL midrst_async: got %b want 10001", {dout_m, bv_m, last_m, busy_m, ready_m});
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        test_single_msb(8'hFF, "after_rst");
    endtask

    task automatic test_ignore_midframe();
        exp_t e;
        @(negedge clk);
        data_m = 8'h01;
        valid_m = 1'b1;
        push_word(8'h01, 1'b1);
        @(negedge clk);
        valid_m = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i == 3) begin
                valid_m = 1'b1;
                data_m = 8'h00;
            end
            if (i == 4) valid_m = 1'b0;
            checks++;
            e = exp_q.pop_front();
            if ({dout_m, last_m, bv_m} !== {e.d, e.last, 1'b1}) begin
                errors++;
                $display("FAIL ignore_bit%0d: got %b want %b", i, {dout_m, last_m, bv_m}, {e.d, e.last, 1'b1});
            end
            @(negedge clk);
        end
        checks++;
        if ({bv_m, busy_m, exp_q.size() == 0} !== 3'b001) begin
            errors++;
            $display("FAIL ignore_idle_after: got bv/busy/qempty=%b want 001", {bv_m, busy_m, exp_q.size() == 0});
        end
    endtask

`ifdef ZERO_PARITY_APPEND_EN
    task automatic test_parity(input logic [W-1:0] w, input logic par);
        @(negedge clk);
        data_m = w;
        valid_m = 1'b1;
        @(negedge clk);
        valid_m = 1'b0;
        repeat (W) @(negedge clk);
        checks++;
        if ({dout_m, last_m, bv_m} !== {par, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL parity_%h: got d/last/bv=%b want %b", w, {dout_m, last_m, bv_m}, {par, 1'b1, 1'b1});
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_msb(8'hA5, "single_a5");
        test_back_to_back();
        test_lsb_first();
        test_reset_midframe();
        test_ignore_midframe();
`ifdef ZERO_PARITY_APPEND_EN
        test_parity(8'hA5, 1'b1);
        test_parity(8'h01, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zero_par_serializer.md
Name: zero_par_serializer

Overview:
- Parallel-to-serial stage directly upstream of the zero-parity checker.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a serial line, with a bit-valid qualifier and an end-of-frame marker.
- Back-to-back words stream with no idle bubble. Between frames the line idles high, so a downstream zero counter sees no spurious zeros.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first, 0 = shift out bit 0 first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  parallel word to serialize.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  1  serial bit, registered.
- bit_valid_o  output  1  data_o carries a frame bit this cycle.
- last_o  output  1  current bit is the final bit of the frame.
- busy_o  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Clock and reset:
  - One clock, one reset. Reset is asynchronous and active-high, and applies immediately without waiting for clk.
- Reset values:
  - state=IDLE, shift register=0, bit counter=0.
  - data_o=1, bit_valid_o=0, last_o=0, busy_o=0, ready_o=1.
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being shifted out.
- Bit counter:
  - Width is clog2(FRAME_LEN+1).
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature enabled.
- Handshake:
  - Transfer occurs on a rising edge when valid_i=1 and ready_o=1.
  - ready_o = (state==IDLE) or (state==SHIFT and counter==FRAME_LEN-1). This is combinational from registered state only; it has no path from valid_i.
  - valid_i while ready_o=0 is ignored. data_i is not sampled.
- Transitions:
  - IDLE to SHIFT on transfer. The word is captured and the counter cleared.
  - SHIFT, counter<FRAME_LEN-1: shift one position and increment the counter.
  - SHIFT, counter==FRAME_LEN-1, transfer: reload with the new word, clear the counter, stay in SHIFT.
  - SHIFT, counter==FRAME_LEN-1, no transfer: go to IDLE.
- Latency: a word accepted on edge N puts its first bit on data_o in the cycle after edge N. A frame occupies exactly FRAME_LEN consecutive cycles.
- Outputs in SHIFT:
  - bit_valid_o=1, busy_o=1.
  - data_o = current head bit: MSB if MSB_FIRST, else LSB.
  - last_o=1 only when counter==FRAME_LEN-1.
- Outputs in IDLE: data_o=1, bit_valid_o=0, last_o=0, busy_o=0.
- Reset mid-frame: the frame is aborted and the remaining bits are discarded. Outputs return to reset values asynchronously. The next transfer starts a clean frame.
- valid_i/data_i may change freely while ready_o=0.

Optional Feature:
- Macro: ZERO_PARITY_APPEND_EN.
- Enabled:
  - One parity bit is appended after the WIDTH data bits, so FRAME_LEN=WIDTH+1 and last_o marks the parity bit.
  - The parity bit is computed from data_i at the transfer edge and stored with the word.
  - Value: 0 if the word contains an odd number of zeros, 1 if even. Every frame therefore carries an even count of zeros.
- Disabled:
  - FRAME_LEN=WIDTH and no parity logic is present.

Test Plan:
1. Assert reset with clk stopped -> ready_o=1, data_o=1, bit_valid_o=0, last_o=0, busy_o=0 without any clock edge.
2. WIDTH=8, MSB_FIRST=1, transfer 8'hA5 with valid_i then deasserted -> data_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; last_o on the 8th bit only; ready_o=0 on bits 1-7 and 1 on bit 8; then IDLE with data_o=1.
3. valid_i held with 8'hA5 then 8'h0F -> 16 contiguous bit_valid_o cycles, second frame 0,0,0,0,1,1,1,1, last_o on bits 8 and 16, no gap cycle.
4. MSB_FIRST=0, transfer 8'h01 -> data_o = 1,0,0,0,0,0,0,0.
5. Assert reset after 3 bits of 8'h00, then transfer 8'hFF -> immediate IDLE values; the next frame is eight 1s with no leftover zeros.
6. With ZERO_PARITY_APPEND_EN defined:
   - 8'hA5 (4 zeros) -> 9 bits, parity bit 1, last_o on bit 9.
   - 8'h01 (7 zeros) -> parity bit 0.
   - Pulse valid_i mid-frame -> ignored, frame intact.
